// File: rtl/mmio_dma_copy.sv
// Word-copy DMA initiator for the valid/ready MMIO bus: reads one word from src,
// writes it to dst, repeats len times, with a per-request ready timeout.
module mmio_dma_copy #(
  parameter int unsigned LEN_W   = 16,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [LEN_W-1:0] words_done,
  output logic [31:0]      m_addr,
  output logic [31:0]      m_wdata,
  output logic [3:0]       m_wstrb,
  output logic             m_we,
  output logic             m_valid,
  input  logic [31:0]      m_rdata,
  input  logic             m_ready
);

  localparam int unsigned TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RD_GAP,
    S_WR,
    S_WR_GAP
  } state_t;

  state_t            state, state_d;
  logic [31:0]       rd_ptr, rd_ptr_d;
  logic [31:0]       wr_ptr, wr_ptr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [TCNT_W-1:0] tcnt, tcnt_d;
  logic              abort;

  logic              busy_d, done_d, error_d;
  logic [LEN_W-1:0]  words_done_d;
  logic [31:0]       m_addr_d, m_wdata_d;
  logic [3:0]        m_wstrb_d;
  logic              m_we_d, m_valid_d;

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d      = state;
    rd_ptr_d     = rd_ptr;
    wr_ptr_d     = wr_ptr;
    len_d        = len_q;
    tcnt_d       = tcnt;
    abort        = 1'b0;
    busy_d       = busy;
    done_d       = 1'b0;
    error_d      = error;
    words_done_d = words_done;
    m_addr_d     = m_addr;
    m_wdata_d    = m_wdata;
    m_wstrb_d    = m_wstrb;
    m_we_d       = m_we;
    m_valid_d    = m_valid;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          len_d        = len;
          rd_ptr_d     = src_addr & WORD_MASK;
          wr_ptr_d     = dst_addr & WORD_MASK;
          tcnt_d       = '0;
          error_d      = 1'b0;
          words_done_d = '0;
          if (len == '0) begin
            done_d = 1'b1;
            busy_d = 1'b0;
          end else begin
            busy_d    = 1'b1;
            m_valid_d = 1'b1;
            m_we_d    = 1'b0;
            m_wstrb_d = 4'h0;
            m_addr_d  = src_addr & WORD_MASK;
            state_d   = S_RD;
          end
        end
      end

      S_RD: begin
        if (m_ready) begin
          m_wdata_d = m_rdata;
          m_valid_d = 1'b0;
          rd_ptr_d  = rd_ptr + 32'd4;
          state_d   = S_RD_GAP;
        end else if (tcnt == TCNT_LAST) begin
          abort = 1'b1;
        end else begin
          tcnt_d = tcnt + TCNT_W'(1);
        end
      end

      S_RD_GAP: begin
        m_valid_d = 1'b1;
        m_we_d    = 1'b1;
        m_wstrb_d = 4'hF;
        m_addr_d  = wr_ptr;
        tcnt_d    = '0;
        state_d   = S_WR;
      end

      S_WR: begin
        if (m_ready) begin
          words_done_d = words_done + LEN_W'(1);
          m_valid_d    = 1'b0;
          m_we_d       = 1'b0;
          m_wstrb_d    = 4'h0;
          wr_ptr_d     = wr_ptr + 32'd4;
          state_d      = S_WR_GAP;
        end else if (tcnt == TCNT_LAST) begin
          abort = 1'b1;
        end else begin
          tcnt_d = tcnt + TCNT_W'(1);
        end
      end

      S_WR_GAP: begin
        if (words_done == len_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          m_valid_d = 1'b1;
          m_we_d    = 1'b0;
          m_wstrb_d = 4'h0;
          m_addr_d  = rd_ptr;
          tcnt_d    = '0;
          state_d   = S_RD;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Stalled request: drop the bus and report; words_done keeps completed writes.
    if (abort) begin
      m_valid_d = 1'b0;
      m_we_d    = 1'b0;
      m_wstrb_d = 4'h0;
      error_d   = 1'b1;
      done_d    = 1'b1;
      busy_d    = 1'b0;
      state_d   = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      len_q      <= '0;
      tcnt       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      words_done <= '0;
      m_addr     <= '0;
      m_wdata    <= '0;
      m_wstrb    <= 4'h0;
      m_we       <= 1'b0;
      m_valid    <= 1'b0;
    end else begin
      state      <= state_d;
      rd_ptr     <= rd_ptr_d;
      wr_ptr     <= wr_ptr_d;
      len_q      <= len_d;
      tcnt       <= tcnt_d;
      busy       <= busy_d;
      done       <= done_d;
      error      <= error_d;
      words_done <= words_done_d;
      m_addr     <= m_addr_d;
      m_wdata    <= m_wdata_d;
      m_wstrb    <= m_wstrb_d;
      m_we       <= m_we_d;
      m_valid    <= m_valid_d;
    end
  end

endmodule

// File: tb/tb_mmio_dma_copy.sv
// Directed bench for mmio_dma_copy with a registered-ready RAM responder.
module tb_mmio_dma_copy;

  localparam int unsigned LEN_W   = 16;
  localparam int unsigned TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [31:0]      src_addr = '0;
  logic [31:0]      dst_addr = '0;
  logic [LEN_W-1:0] len = '0;
  logic             busy, done, error;
  logic [LEN_W-1:0] words_done;
  logic [31:0]      m_addr, m_wdata, m_rdata;
  logic [3:0]       m_wstrb;
  logic             m_we, m_valid, m_ready;

  mmio_dma_copy #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .len(len), .busy(busy), .done(done), .error(error), .words_done(words_done),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_we(m_we),
    .m_valid(m_valid), .m_rdata(m_rdata), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int i);
    return (i == 0) ? 32'hDEAD_BEEF : (32'hA500_0000 | 32'(i));
  endfunction

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } hs_t;

  // Responder modes: 0 ready once per request, 1 ready echoes valid (re-acks in gaps),
  // 2 never ready, 3 ready for reads only.
  int          mode = 0;
  logic [31:0] ram [0:1023];
  hs_t         log_q[$];

  assign m_rdata = ram[m_addr[11:2]];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ready <= 1'b0;
      for (int i = 0; i < 1024; i++) ram[i] <= pat(i);
    end else begin
      case (mode)
        0:       m_ready <= m_valid && !m_ready;
        1:       m_ready <= m_valid;
        2:       m_ready <= 1'b0;
        default: m_ready <= m_valid && !m_ready && !m_we;
      endcase
      if (m_valid && m_ready) begin
        log_q.push_back('{m_addr, m_we, m_wdata});
        if (m_we) ram[m_addr[11:2]] <= m_wdata;
      end
    end
  end

  // Bus-rule monitor: stable request, strobes vs we, done single-cycle and exclusive of busy.
  logic        pv = 1'b0, pr = 1'b0, pwe = 1'b0, pdone = 1'b0;
  logic [31:0] pa = '0, pd = '0;
  logic [3:0]  ps = '0;
  int          proto_err = 0;
  logic        viol;
  assign viol = (pv && !pr && m_valid && ({m_addr, m_we, m_wdata, m_wstrb} != {pa, pwe, pd, ps}))
             || (m_valid && (m_wstrb != (m_we ? 4'hF : 4'h0)))
             || (busy && done) || (pdone && done);

  always @(negedge clk) begin
    if (viol) proto_err <= proto_err + 1;
    pv <= m_valid; pr <= m_ready; pwe <= m_we; pdone <= done;
    pa <= m_addr;  pd <= m_wdata; ps <= m_wstrb;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Start a transfer (start high for one edge), then sample each cycle until done+2.
  task automatic run(input int md, input logic [31:0] s, input logic [31:0] d,
                     input logic [LEN_W-1:0] l, input int extra_at,
                     output int done_c, output int vcnt, output logic busy1);
    mode = md;
    @(negedge clk);
    log_q.delete();
    src_addr = s; dst_addr = d; len = l; start = 1'b1;
    @(posedge clk);
    done_c = 0; vcnt = 0; busy1 = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      start = (c == extra_at);
      if (c == extra_at) begin
        src_addr = 32'h4000_4F00; dst_addr = 32'h0; len = '0;
      end
      if (c == 1) busy1 = busy;
      if (m_valid) vcnt++;
      if (done && done_c == 0) done_c = c;
      if (done_c != 0 && c >= done_c + 2) break;
    end
  endtask

  typedef struct {
    int          md;
    logic [31:0] src;
    logic [31:0] dst;
    int          n;
    int          exp_done;
    int          exp_words;
    logic        exp_err;
    int          exp_valid;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int          dc, vc, sidx, didx;
    logic        b1;
    logic [31:0] sa, da;

    vecs[0] = '{0, 32'h4000_4000, 32'h4000_4010, 1,  7, 1, 1'b0,  4};
    vecs[1] = '{0, 32'h4000_4000, 32'h4000_4100, 4, 25, 4, 1'b0, 16};
    vecs[2] = '{0, 32'h4000_4000, 32'h4000_4500, 0,  1, 0, 1'b0,  0};
    vecs[3] = '{2, 32'h4000_4000, 32'h4000_4600, 3, 17, 0, 1'b1, 16};
    vecs[4] = '{3, 32'h4000_4000, 32'h4000_4600, 2, 20, 0, 1'b1, 18};
    vecs[5] = '{0, 32'h4000_4002, 32'h4000_4383, 2, 13, 2, 1'b0,  8};
    vecs[6] = '{1, 32'h4000_4080, 32'h4000_4300, 3, 19, 3, 1'b0, 12};

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_words", 32'(words_done), 32'd0);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_addr", m_addr, 32'd0);
    chk("rst_wstrb", 32'(m_wstrb), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_valid", 32'(m_valid), 32'd0);

    for (int v = 0; v < 7; v++) begin
      run(vecs[v].md, vecs[v].src, vecs[v].dst, LEN_W'(vecs[v].n), 0, dc, vc, b1);
      chk($sformatf("v%0d_done_cycle", v), 32'(dc), 32'(vecs[v].exp_done));
      chk($sformatf("v%0d_valid_cycles", v), 32'(vc), 32'(vecs[v].exp_valid));
      chk($sformatf("v%0d_words", v), 32'(words_done), 32'(vecs[v].exp_words));
      chk($sformatf("v%0d_error", v), 32'(error), 32'(vecs[v].exp_err));
      chk($sformatf("v%0d_busy1", v), 32'(b1), 32'(vecs[v].n != 0));
      chk($sformatf("v%0d_busy_end", v), 32'(busy), 32'd0);
      if (vecs[v].md <= 1) begin
        sa = vecs[v].src & 32'hFFFF_FFFC;
        da = vecs[v].dst & 32'hFFFF_FFFC;
        sidx = int'((sa - 32'h4000_4000) >> 2);
        didx = int'((da - 32'h4000_4000) >> 2);
        chk($sformatf("v%0d_hs_count", v), 32'(log_q.size()), 32'(2 * vecs[v].n));
        if (log_q.size() == 2 * vecs[v].n) begin
          for (int k = 0; k < vecs[v].n; k++) begin
            chk($sformatf("v%0d_rd%0d_addr", v, k), log_q[2*k].addr, sa + 32'(4 * k));
            chk($sformatf("v%0d_rd%0d_we", v, k), 32'(log_q[2*k].we), 32'd0);
            chk($sformatf("v%0d_wr%0d_addr", v, k), log_q[2*k+1].addr, da + 32'(4 * k));
            chk($sformatf("v%0d_wr%0d_data", v, k), log_q[2*k+1].wdata, pat(sidx + k));
            chk($sformatf("v%0d_ram%0d", v, k), ram[didx + k], pat(sidx + k));
          end
        end
      end
    end

    // Re-acking responder plus a stray start mid-transfer with different inputs.
    run(1, 32'h4000_4040, 32'h4000_4200, LEN_W'(3), 8, dc, vc, b1);
    chk("midstart_done_cycle", 32'(dc), 32'd19);
    chk("midstart_words", 32'(words_done), 32'd3);
    chk("midstart_error", 32'(error), 32'd0);
    chk("midstart_hs_count", 32'(log_q.size()), 32'd6);
    for (int k = 0; k < 3; k++)
      chk($sformatf("midstart_ram%0d", k), ram[128 + k], pat(16 + k));

    // Reset during the write of the second word of four.
    mode = 0;
    @(negedge clk);
    src_addr = 32'h4000_4000; dst_addr = 32'h4000_4180; len = LEN_W'(4); start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre_rst_valid", 32'(m_valid), 32'd1);
    chk("pre_rst_we", 32'(m_we), 32'd1);
    chk("pre_rst_words", 32'(words_done), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(m_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_words", 32'(words_done), 32'd0);
    chk("mid_rst_we", 32'(m_we), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run(0, 32'h4000_4000, 32'h4000_4180, LEN_W'(1), 0, dc, vc, b1);
    chk("post_rst_done_cycle", 32'(dc), 32'd7);
    chk("post_rst_words", 32'(words_done), 32'd1);
    chk("post_rst_ram", ram[96], 32'hDEAD_BEEF);

    chk("protocol", 32'(proto_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_dma_copy.md
# mmio_dma_copy

Bus initiator that copies a block of 32-bit words from a source address to a destination address over the SoC's valid/ready MMIO bus. It is the initiator end of the protocol served by the crypto peripherals and the scratch RAM. It moves key, plaintext and result buffers between the RAM window (0x4000_4000) and the accelerator register windows without CPU load/store traffic. Firmware programs source, destination and length, pulses start, then polls busy/done/error.

## Interface
- `LEN_W`, 16: width of the word-count field.
- `TIMEOUT`, 256: cycles a single bus request may wait for `m_ready` before the transfer is aborted.
- `clk`  in  1  single clock domain; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; sampled only in IDLE.
- `src_addr`  in  32  source byte address; bits [1:0] ignored (forced 00).
- `dst_addr`  in  32  destination byte address; bits [1:0] ignored.
- `len`  in  LEN_W  number of words to copy.
- `busy`  out  1  high from the cycle after an accepted start until done.
- `done`  out  1  one-cycle pulse at transfer end (normal or aborted).
- `error`  out  1  sticky timeout flag; cleared by the next accepted start.
- `words_done`  out  LEN_W  words fully written in the current or last transfer.
- `m_addr`  out  32  bus address.
- `m_wdata`  out  32  bus write data.
- `m_wstrb`  out  4  byte strobes; 4'hF on writes, 4'h0 on reads.
- `m_we`  out  1  1 = write, 0 = read.
- `m_valid`  out  1  request valid.
- `m_rdata`  in  32  read data; valid when `m_ready` is high.
- `m_ready`  in  1  responder completion.

## Operation
- All outputs reset to 0. `src`, `dst`, `len` and `start` are latched on an accepted start. Inputs are don't-care while busy.
- States: IDLE, RD, RD_GAP, WR, WR_GAP.
- IDLE: on `start`, latch the inputs, clear `error` and `words_done`, and set `busy`. If `len`==0, pulse `done` next cycle, drop `busy`, and issue no bus traffic. Otherwise go to RD.
- RD: `m_valid`=1, `m_we`=0, `m_addr`=src+4*i. When `m_ready`=1, capture `m_rdata` into the data buffer and go to RD_GAP.
- RD_GAP: `m_valid`=0 for exactly one cycle. Then go to WR.
- WR: `m_valid`=1, `m_we`=1, `m_wstrb`=4'hF, `m_wdata`=buffer, `m_addr`=dst+4*i. When `m_ready`=1, increment `words_done` and go to WR_GAP.
- WR_GAP: `m_valid`=0 for one cycle. If `words_done`==len, return to IDLE with a `done` pulse and `busy`=0. Otherwise i++ and go to RD.
- Any `m_ready` seen in RD_GAP or WR_GAP is ignored. Responders register ready one cycle late and may re-acknowledge the trailing valid cycle.
- `m_addr`, `m_we`, `m_wdata` and `m_wstrb` are stable for the whole time `m_valid` is high.
- Address arithmetic is modulo 2^32; wrap-around past 0xFFFF_FFFC is not flagged.
- Timeout: a per-request counter clears on entry to RD or WR. If it reaches TIMEOUT with no `m_ready`, then in the next cycle: `m_valid`=0, `error`=1, `done` pulses, `busy`=0, state returns to IDLE. `words_done` holds the count of completed writes.
- `start` while busy is ignored and has no side effects.
- `rst` asserted mid-transfer: every output goes to 0 immediately and the FSM goes to IDLE. The partial write in flight is abandoned.

## Timing
- All outputs are registered.
- With a responder that asserts ready one cycle after valid, each word takes 6 cycles: RD 2, RD_GAP 1, WR 2, WR_GAP 1.
- Start sampled at edge 0: first `m_valid` appears in cycle 1. `done` is high in cycle 6N+1 and `busy` is low from that cycle.
- len=0: `done` is high in cycle 1.
- Timeout abort: `m_valid` is high for exactly TIMEOUT cycles of the stalled request. `done` is high in the following cycle.
- `done` is never high for more than one cycle. `busy` and `done` are never high together.

## Test plan
- len=1, src=0x4000_4000 holding 0xDEADBEEF, dst=0x4000_4010: expect one read, then one write with wstrb=F and wdata=0xDEADBEEF. Expect `done` in cycle 7, RAM word 4 = 0xDEADBEEF, `words_done`=1.
- len=4, src=0x4000_4000, dst=0x4000_4100: expect read addresses 0x..00/04/08/0C interleaved with writes 0x..100/104/108/10C. Expect `done` in cycle 25 and destination equal to source.
- len=0: expect `done` in cycle 1, `m_valid` never high, `error`=0.
- Stalled responder (`m_ready` tied 0) with TIMEOUT=16: expect `m_valid` high for 16 cycles, then `error`=1, `done` pulse, `words_done`=0. The next start clears `error`.
- Responder that re-asserts `m_ready` during each gap cycle, plus a `start` pulsed mid-transfer: expect no duplicate counts, correct `words_done`, and the transfer unaffected by the extra start.
- Assert `rst` while in WR of word 2 of 4: expect `m_valid`, `busy`, `done` and `words_done` all 0 in the same cycle. A subsequent start runs normally from IDLE.
